// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline and the iterative RV32M multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
        input  stall_o, valid_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
        output stall_o, valid_o, result_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps on operand magnitudes.
// Optional macro MULDIV_EARLY_OUT_EN finishes zero-operand multiplies and zero-divisor divides in one cycle.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q;
    logic            neg_a_q, neg_b_q, div_zero_q;
    logic [5:0]      cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, opb_q, result_q;

    logic            start_op, step, load_result, stall, valid;
    logic            signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;

    // Operand sign flags: MULH, DIV and REM are fully signed; MULHSU signs only A.
    always_comb begin
        signed_a = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                   (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
        signed_b = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                   (bus.funct3_i == 3'b110);
        neg_a    = signed_a && bus.rs1_data_i[XLEN-1];
        neg_b    = signed_b && bus.rs2_data_i[XLEN-1];
        abs_a    = neg_a ? -bus.rs1_data_i : bus.rs1_data_i;
        abs_b    = neg_b ? -bus.rs2_data_i : bus.rs2_data_i;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit, load_early;
    logic [XLEN-1:0] early_result;

    always_comb begin
        early_result = '0;
        if (bus.funct3_i[2]) begin
            early_hit = (bus.rs2_data_i == '0);
            if (bus.funct3_i[1]) early_result = bus.rs1_data_i;
            else                 early_result = '1;
        end else begin
            early_hit = (bus.rs1_data_i == '0) || (bus.rs2_data_i == '0);
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        start_op    = 1'b0;
        step        = 1'b0;
        load_result = 1'b0;
        stall       = 1'b0;
        valid       = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        load_early  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                stall = bus.start_i;
                if (bus.start_i && !bus.flush_i) begin
                    start_op = 1'b1;
                    state_d  = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        load_early = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end
            CALC: begin
                stall = 1'b1;
                step  = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd31) begin
                    load_result = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   iter_hi, iter_lo;

    // One iteration: hi:lo is the product accumulator or the remainder:quotient pair.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift[XLEN] || (div_shift[XLEN-1:0] >= opb_q);
        div_diff  = div_shift[XLEN-1:0] - opb_q;
        if (funct3_q[2]) begin
            iter_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            iter_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[XLEN:1];
            iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quotient, remainder, result_calc;

    always_comb begin
        prod      = {iter_hi, iter_lo};
        quotient  = iter_lo;
        remainder = neg_a_q ? -iter_hi : iter_hi;
        if (neg_a_q ^ neg_b_q) begin
            prod = -{iter_hi, iter_lo};
            // A zero divisor keeps the all-ones quotient unsigned.
            if (!div_zero_q) quotient = -iter_lo;
        end
        case (funct3_q)
            3'b000:                 result_calc = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_calc = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_calc = quotient;
            default:                result_calc = remainder;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_op) begin
                funct3_q   <= bus.funct3_i;
                neg_a_q    <= neg_a;
                neg_b_q    <= neg_b;
                div_zero_q <= (bus.rs2_data_i == '0);
                cnt_q      <= '0;
                hi_q       <= '0;
                lo_q       <= abs_a;
                opb_q      <= abs_b;
            end else if (step) begin
                cnt_q <= cnt_q + 6'd1;
                hi_q  <= iter_hi;
                lo_q  <= iter_lo;
            end
            if (load_result) result_q <= result_calc;
`ifdef MULDIV_EARLY_OUT_EN
            if (load_early) result_q <= early_result;
`endif
        end
    end

    assign bus.stall_o  = stall;
    assign bus.valid_o  = valid;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: RV32M result vectors, latency and stall timing, flush and reset aborts.
// Build with MULDIV_EARLY_OUT_EN defined to check the one-cycle zero-operand path.
module tb_muldiv_ctrl;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    localparam int LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        zero_path;
    } vec_t;

    vec_t tab [18];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        bus.funct3_i   = v.f;
        bus.rs1_data_i = v.a;
        bus.rs2_data_i = v.b;
        bus.start_i    = 1'b1;
    endtask

    // Called at the falling edge of cycle 0 with start_i high; returns at the falling edge of DONE.
    task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic stall_ok;
        #1 check({tag, " stall_c0"}, 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        lat      = 1;
        stall_ok = 1'b1;
        while (!bus.valid_o && lat <= 40) begin
            stall_ok &= bus.stall_o;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall_calc"}, 32'(stall_ok), 32'd1);
        check({tag, " stall_done"}, 32'(bus.stall_o), 32'd0);
        check({tag, " result"}, bus.result_o, exp);
    endtask

    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid_o) pulses++;
        end
    endtask

    initial begin
        logic [31:0] last_exp;
        int          pulses;

        bus.start_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.funct3_i   = 3'b000;
        bus.rs1_data_i = '0;
        bus.rs2_data_i = '0;

        tab[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        tab[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        tab[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tab[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        tab[4]  = '{3'b001, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0};
        tab[5]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        tab[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        tab[7]  = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tab[8]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        tab[9]  = '{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
        tab[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        tab[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tab[12] = '{3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1};
        tab[13] = '{3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0};
        tab[14] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        tab[15] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
        tab[16] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
        tab[17] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset valid", 32'(bus.valid_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset stall", 32'(bus.stall_o), 32'd0);

        // Each next op is offered already in the DONE cycle; it must only be taken in the cycle after.
        @(negedge clk);
        issue(tab[0]);
        for (int i = 0; i < 18; i++) begin
            wait_result($sformatf("v%0d", i), tab[i].exp, tab[i].zero_path ? ZLAT : LAT);
            last_exp = tab[i].exp;
            if (i < 17) begin
                issue(tab[i+1]);
                #1 check($sformatf("v%0d done_start_stall", i), 32'(bus.stall_o), 32'd0);
                @(negedge clk);
                check($sformatf("v%0d gap_valid", i), 32'(bus.valid_o), 32'd0);
            end
        end

        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        issue('{3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0, 1'b0});
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("flush stall_c11", 32'(bus.stall_o), 32'd0);
        check("flush valid_c11", 32'(bus.valid_o), 32'd0);
        check("flush result_held", bus.result_o, last_exp);
        count_valid(40, pulses);
        check("flush valid_pulses", 32'(pulses), 32'd0);

        // Reset in cycle 10 of a DIV.
        @(negedge clk);
        issue('{3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0, 1'b0});
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst stall_c11", 32'(bus.stall_o), 32'd0);
        check("rst valid_c11", 32'(bus.valid_o), 32'd0);
        check("rst result", bus.result_o, 32'd0);
        count_valid(40, pulses);
        check("rst valid_pulses", 32'(pulses), 32'd0);

        // Start and flush together in IDLE: stall is still raised, nothing is accepted.
        @(negedge clk);
        issue(tab[0]);
        bus.flush_i = 1'b1;
        #1 check("sflush stall_c0", 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1 check("sflush stall_c1", 32'(bus.stall_o), 32'd0);
        count_valid(40, pulses);
        check("sflush valid_pulses", 32'(pulses), 32'd0);

        // The unit still works after the aborts.
        @(negedge clk);
        issue(tab[0]);
        wait_result("post", tab[0].exp, LAT);
        @(negedge clk);
        check("post valid_drop", 32'(bus.valid_o), 32'd0);
        check("post result_hold", bus.result_o, tab[0].exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative RV32M multiply/divide unit with its sequencing FSM, sitting in EX beside the single-cycle ALU. It accepts one M-extension operation from ID/EX, holds the pipeline via a stall request while it iterates, and presents the 32-bit result for one cycle so EX/MEM can capture it. The hazard unit ORs `stall_o` into its own stall.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk_i`  input  1  clock. One clock domain; everything updates on the rising edge.
- `rst_i`  input  1  reset. Synchronous and active-high.
- `start_i`  input  1  EX holds a valid M-extension instruction (opcode 0110011, funct7 = 0000001).
- `funct3_i`  input  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data_i`  input  32  forwarded operand A.
- `rs2_data_i`  input  32  forwarded operand B.
- `flush_i`  input  1  branch/jump flush of the EX instruction.
- `stall_o`  output  1  freeze PC, IF/ID and ID/EX.
- `valid_o`  output  1  `result_o` is valid this cycle.
- `result_o`  output  32  operation result.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- **IDLE**
  - `stall_o = start_i`, combinational.
  - On `start_i` (and no `flush_i`) latch `funct3`, the operand magnitudes and the sign flags, clear the 6-bit counter, go to CALC.
- **CALC**
  - `stall_o = 1`.
  - Each cycle performs one iteration: shift-add for multiply, restoring subtract-shift for divide.
  - The counter increments each cycle; go to DONE when the counter reaches 31 (32 iterations).
- **DONE**
  - `stall_o = 0`, `valid_o = 1`, `result_o` driven from registers.
  - `start_i` is ignored here, because the same instruction is still in EX.
  - Always return to IDLE on the next edge.
- **Signed handling**
  - Operands are converted to magnitudes before iteration.
  - MULH: A and B are signed. MULHSU: A signed, B unsigned. DIV/REM: both signed.
  - Product is negated when the sign flags differ.
  - Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
- **Result select**
  - MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
  - DIV/DIVU take the quotient; REM/REMU take the remainder.
- **Divide by zero:** quotient = 0xFFFFFFFF with no sign correction; remainder = dividend.
- **Signed overflow** (0x80000000 / -1): quotient 0x80000000, remainder 0. This falls out of magnitude arithmetic with no special case.
- **`flush_i`** in any state returns the FSM to IDLE on the next edge.
  - `valid_o` is 0 the following cycle.
  - No result is produced.
- **`rst_i`** has priority over `flush_i` and `start_i`. Mid-operation it aborts to IDLE.

## Timing
- **Reset values:** state IDLE, `valid_o = 0`, `result_o = 0`, counter 0. `stall_o = 0` whenever `start_i = 0`.
- **Latency:**
  - Cycle 0: `start_i` sampled.
  - Cycles 1–32: CALC.
  - Cycle 33: DONE, `valid_o = 1`.
  - `stall_o` is high in cycles 0–32, 33 cycles in total.
- **Back-to-back operations:** the earliest next start is cycle 34 (IDLE). `start_i` in cycle 33 is never accepted.
- **Simultaneous events:** `flush_i` and `start_i` in the same IDLE cycle means the FSM stays in IDLE, but `stall_o` is still 1 that cycle (combinational).
- `result_o` holds its last value outside DONE. Consumers must qualify it with `valid_o`.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- **Defined:** in IDLE, if either multiply operand is zero or the divisor is zero, go directly to DONE.
  - Multiply result is 0.
  - Divide-by-zero results are as specified in Operation.
  - Latency is 1 cycle: `valid_o` in cycle 1 and `stall_o` high only in cycle 0.
- **Undefined:** every operation takes the full 33-cycle sequence. Results are identical either way.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result_o = 0xFFFFFFEB`; `valid_o` in cycle 33; `stall_o` high cycles 0–32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 0x80000000 / 0xFFFFFFFF → 0x00000000.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 0x00000005; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Assert `flush_i` in cycle 10 of a DIV → IDLE at cycle 11, `stall_o = 0`, no `valid_o` pulse. Repeat with `rst_i` in cycle 10 → same outcome, and `result_o = 0`.
- With `MULDIV_EARLY_OUT_EN` defined, MUL 0 × 5 → `valid_o` in cycle 1 with result 0. A new `start_i` in cycle 2 is accepted.
